alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the team's fixed 8-bit, 2-stage ALU.
- Operand width is `DATA_W`; results are `2*DATA_W` wide.
- Valid/ready flow control is added on input and output, with backpressure.
- Unsigned modulo is a multi-cycle iterative operation with a divide-by-zero flag.
- Sits between an operand-issuing controller and a result consumer; results leave strictly in order.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_divider.sv | 85 ++++++++
 rtl/alu_pipe.sv | 161 ++++++++++++++++
 tb/tb_alu_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared opcode type and opcode constants for the alu_pipe datapath.
// Imported by alu_pipe.
// ---------------------------------------------------------------------------
package alu_pkg;

  // 3-bit opcode carried through the pipeline
  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'b000;  // sx(a) + sx(b)
  localparam op_t OP_SUB = 3'b001;  // sx(a) - sx(b)
  localparam op_t OP_MUL = 3'b010;  // a * b, unsigned
  localparam op_t OP_AND = 3'b011;  // sx(a) & sx(b)
  localparam op_t OP_XOR = 3'b100;  // sx(a) ^ sx(b)
  localparam op_t OP_ABS = 3'b101;  // |a|, a signed, zero-extended
  localparam op_t OP_AVG = 3'b110;  // (sx(a) + sx(b)) >>> 1
  localparam op_t OP_MOD = 3'b111;  // a mod b, unsigned, iterative

endpackage

// File: rtl/alu_divider.sv
// ---------------------------------------------------------------------------
// alu_divider
// Restoring unsigned remainder unit, one dividend bit per clock.
//   clk_p_i    : clock, rising edge
//   reset_n_i  : asynchronous active-low reset (aborts any operation)
//   start_i    : load a_i/b_i and begin; only pulsed while not busy
//   a_i, b_i   : dividend / divisor
//   busy_o     : iterations in progress
//   done_o     : rem_o/dz_o valid; held until the next start_i
//   rem_o      : a mod b (equals a when b == 0)
//   dz_o       : divisor was zero
// Timing: start edge + DATA_W iteration edges, done_o high after the last.
// ---------------------------------------------------------------------------
module alu_divider #(
  parameter int DATA_W = 8
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rem_o,
  output logic              dz_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              r_busy;
  logic              r_done;
  logic              r_dz;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_dvd;   // dividend, shifted out MSB first
  logic [DATA_W-1:0] r_div;
  logic [DATA_W-1:0] r_rem;

  logic [DATA_W:0]   w_trial;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_rem_next;

  // Partial remainder with the next dividend bit appended; the borrow of
  // the trial subtraction decides whether to restore. With b == 0 the
  // subtraction never borrows, so r_rem simply shifts in all of a and ends
  // up equal to a -- exactly the divide-by-zero result required.
  always_comb begin
    w_trial    = {r_rem, r_dvd[DATA_W-1]};
    w_diff     = w_trial - {1'b0, r_div};
    w_rem_next = w_diff[DATA_W] ? w_trial[DATA_W-1:0] : w_diff[DATA_W-1:0];
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_div  <= '0;
      r_rem  <= '0;
    end else if (start_i) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_dz   <= (b_i == '0);
      r_cnt  <= CNT_W'(DATA_W);
      r_dvd  <= a_i;
      r_div  <= b_i;
      r_rem  <= '0;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_dvd <= {r_dvd[DATA_W-2:0], 1'b0};
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign rem_o  = r_rem;
  assign dz_o   = r_dz;

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// Handshaked ALU: S1 operand register -> S2 execute register -> output
// register (OR). Single-cycle ops are computed from S2 into OR; modulo is
// handed to alu_divider when the op enters S2 and S2 stays occupied until
// the remainder moves into OR. Results leave in acceptance order.
//   clk_p_i     : clock, rising edge
//   reset_n_i   : asynchronous active-low reset
//   in_valid_i  / in_ready_o  : operand handshake
//   data_a_i, data_b_i, inst_i: operands and opcode (DATA_W, DATA_W, 3)
//   out_valid_o / out_ready_i : result handshake
//   data_o      : result (2*DATA_W)
//   err_o       : 1 = modulo by zero
// ---------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int OUT_W  = 2 * DATA_W
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [DATA_W-1:0] data_b_i,
  input  logic [2:0]        inst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  data_o,
  output logic              err_o
);

  logic              r_s1_valid;
  op_t               r_s1_op;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;

  logic              r_s2_valid;
  op_t               r_s2_op;
  logic [DATA_W-1:0] r_s2_a;
  logic [DATA_W-1:0] r_s2_b;

  logic              r_or_valid;
  logic [OUT_W-1:0]  r_or_data;
  logic              r_or_err;

  logic              w_in_fire;
  logic              w_or_free;
  logic              w_s2_res_ok;
  logic              w_s2_adv;
  logic              w_s2_free;
  logic              w_s1_adv;
  logic              w_div_start;
  logic              w_div_busy;
  logic              w_div_done;
  logic [DATA_W-1:0] w_div_rem;
  logic              w_div_dz;
  logic [OUT_W-1:0]  w_sa;
  logic [OUT_W-1:0]  w_sb;
  logic [OUT_W-1:0]  w_sum;
  logic [OUT_W-1:0]  w_res;
  logic              w_err;

  // Flow control: OR can take a result if empty or draining this edge;
  // everything upstream only moves when the stage ahead frees up, so the
  // whole chain collapses combinationally from out_ready_i.
  always_comb begin
    w_or_free   = !r_or_valid || out_ready_i;
    w_s2_res_ok = (r_s2_op == OP_MOD) ? (w_div_done && !w_div_busy) : 1'b1;
    w_s2_adv    = r_s2_valid && w_s2_res_ok && w_or_free;
    w_s2_free   = !r_s2_valid || w_s2_adv;
    w_s1_adv    = r_s1_valid && w_s2_free;
    in_ready_o  = !r_s1_valid || w_s1_adv;
    w_in_fire   = in_valid_i && in_ready_o;
    w_div_start = w_s1_adv && (r_s1_op == OP_MOD);
  end

  alu_divider #(
    .DATA_W (DATA_W)
  ) u_divider (
    .clk_p_i   (clk_p_i),
    .reset_n_i (reset_n_i),
    .start_i   (w_div_start),
    .a_i       (r_s1_a),
    .b_i       (r_s1_b),
    .busy_o    (w_div_busy),
    .done_o    (w_div_done),
    .rem_o     (w_div_rem),
    .dz_o      (w_div_dz)
  );

  // Single-cycle datapath from S2. The sign-extended sum cannot overflow
  // OUT_W, so the average is a plain arithmetic shift of it.
  always_comb begin
    w_sa  = {{DATA_W{r_s2_a[DATA_W-1]}}, r_s2_a};
    w_sb  = {{DATA_W{r_s2_b[DATA_W-1]}}, r_s2_b};
    w_sum = w_sa + w_sb;
    w_res = '0;
    unique case (r_s2_op)
      OP_ADD:  w_res = w_sum;
      OP_SUB:  w_res = w_sa - w_sb;
      OP_MUL:  w_res = {{DATA_W{1'b0}}, r_s2_a} * {{DATA_W{1'b0}}, r_s2_b};
      OP_AND:  w_res = w_sa & w_sb;
      OP_XOR:  w_res = w_sa ^ w_sb;
      OP_ABS:  w_res = r_s2_a[DATA_W-1] ? (OUT_W'(0) - w_sa) : w_sa;
      OP_AVG:  w_res = {w_sum[OUT_W-1], w_sum[OUT_W-1:1]};
      OP_MOD:  w_res = {{DATA_W{1'b0}}, w_div_rem};
      default: w_res = '0;
    endcase
    w_err = (r_s2_op == OP_MOD) && w_div_dz;
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_op    <= OP_ADD;
      r_s2_a     <= '0;
      r_s2_b     <= '0;
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_or_err   <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= inst_i;
        r_s1_a     <= data_a_i;
        r_s1_b     <= data_b_i;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_op    <= r_s1_op;
        r_s2_a     <= r_s1_a;
        r_s2_b     <= r_s1_b;
      end else if (w_s2_adv) begin
        r_s2_valid <= 1'b0;
      end

      // Load wins over drain so a simultaneous drain+load leaves no bubble
      if (w_s2_adv) begin
        r_or_valid <= 1'b1;
        r_or_data  <= w_res;
        r_or_err   <= w_err;
      end else if (out_ready_i) begin
        r_or_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_or_valid;
  assign data_o      = r_or_data;
  assign err_o       = r_or_err;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
// Two instances (DATA_W = 8 and 16) checked against an arithmetic reference
// model and an in-order expectation queue. Directed cases carry an expected
// latency; random traffic toggles out_ready to exercise backpressure.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        v8, r8, ov8, or8, e8;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic [15:0] d8;

  logic        v16, r16, ov16, or16, e16;
  logic [15:0] a16, b16;
  logic [2:0]  op16;
  logic [31:0] d16;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   lat8     = -1;
  int   lat16    = -1;
  bit   rnd_en   = 0;
  exp_t q8[$];
  exp_t q16[$];

  alu_pipe #(.DATA_W(8)) u_dut8 (
    .clk_p_i(clk), .reset_n_i(rst_n), .in_valid_i(v8), .in_ready_o(r8),
    .data_a_i(a8), .data_b_i(b8), .inst_i(op8), .out_valid_o(ov8),
    .out_ready_i(or8), .data_o(d8), .err_o(e8)
  );

  alu_pipe #(.DATA_W(16)) u_dut16 (
    .clk_p_i(clk), .reset_n_i(rst_n), .in_valid_i(v16), .in_ready_o(r16),
    .data_a_i(a16), .data_b_i(b16), .inst_i(op16), .out_valid_o(ov16),
    .out_ready_i(or16), .data_o(d16), .err_o(e16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: straight arithmetic on integers from the opcode rules
  function automatic void model(input int w, input logic [2:0] op, input logic [15:0] a,
                                input logic [15:0] b, output logic [31:0] res, output logic err);
    longint ua, ub, sa, sb, half, mask, r;
    ua   = longint'(a);
    ub   = longint'(b);
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    mask = (longint'(1) << (2 * w)) - 1;
    case (op)
      3'd0:    r = sa + sb;
      3'd1:    r = sa - sb;
      3'd2:    r = ua * ub;
      3'd3:    r = sa & sb;
      3'd4:    r = sa ^ sb;
      3'd5:    r = (sa < 0) ? -sa : sa;
      3'd6:    r = (sa + sb) >>> 1;
      3'd7:    r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    res = 32'(r & mask);
    err = (op == 3'd7) && (ub == 0);
  endfunction

  // Random out_ready for both instances while random traffic runs
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) begin
        or8  = ($urandom_range(0, 3) != 0);
        or16 = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor / scoreboard, DATA_W = 8
  initial begin
    bit          hold = 0;
    logic [15:0] hd;
    logic        he;
    exp_t        ent;
    logic [31:0] res;
    logic        err;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          check_eq("hold8_valid", 64'(ov8), 64'(1));
          check_eq("hold8_data", 64'(d8), 64'(hd));
          check_eq("hold8_err", 64'(e8), 64'(he));
        end
        hold = ov8 && !or8;
        hd   = d8;
        he   = e8;
        if (ov8 && or8) begin
          if (q8.size() == 0) begin
            check_eq("spurious8", 64'(ov8), 64'(0));
          end else begin
            ent = q8.pop_front();
            check_eq("data8", 64'(d8), 64'(ent.res));
            check_eq("err8", 64'(e8), 64'(ent.err));
            if (ent.lat >= 0) check_eq("lat8", 64'(cyc - ent.acc), 64'(ent.lat));
          end
        end
        if (v8 && r8) begin
          model(8, op8, 16'(a8), 16'(b8), res, err);
          ent.res = res;
          ent.err = err;
          ent.acc = cyc + 1;
          ent.lat = lat8;
          q8.push_back(ent);
        end
      end
    end
  end

  // Monitor / scoreboard, DATA_W = 16
  initial begin
    bit          hold = 0;
    logic [31:0] hd;
    logic        he;
    exp_t        ent;
    logic [31:0] res;
    logic        err;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          check_eq("hold16_valid", 64'(ov16), 64'(1));
          check_eq("hold16_data", 64'(d16), 64'(hd));
          check_eq("hold16_err", 64'(e16), 64'(he));
        end
        hold = ov16 && !or16;
        hd   = d16;
        he   = e16;
        if (ov16 && or16) begin
          if (q16.size() == 0) begin
            check_eq("spurious16", 64'(ov16), 64'(0));
          end else begin
            ent = q16.pop_front();
            check_eq("data16", 64'(d16), 64'(ent.res));
            check_eq("err16", 64'(e16), 64'(ent.err));
            if (ent.lat >= 0) check_eq("lat16", 64'(cyc - ent.acc), 64'(ent.lat));
          end
        end
        if (v16 && r16) begin
          model(16, op16, a16, b16, res, err);
          ent.res = res;
          ent.err = err;
          ent.acc = cyc + 1;
          ent.lat = lat16;
          q16.push_back(ent);
        end
      end
    end
  end

  // Present one op and hold it until accepted; returns just after the
  // accepting edge with in_valid still high so calls chain back-to-back.
  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int lat);
    bit ok = 0;
    v8 = 1'b1; op8 = op; a8 = a; b8 = b; lat8 = lat;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (r8) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("accept8_timeout", 64'(r8), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int lat);
    bit ok = 0;
    v16 = 1'b1; op16 = op; a16 = a; b16 = b; lat16 = lat;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (r16) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("accept16_timeout", 64'(r16), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // Drop valid and scramble operands; they must be ignored
  task automatic park;
    v8 = 1'b0;  a8 = 8'($urandom);   b8 = 8'($urandom);   op8 = 3'($urandom);
    v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); op16 = 3'($urandom);
  endtask

  task automatic drain;
    for (int t = 0; t < 3000; t++) begin
      if (q8.size() == 0 && q16.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("drain8", 64'(q8.size()), 64'(0));
    check_eq("drain16", 64'(q16.size()), 64'(0));
  endtask

  initial begin
    logic [2:0] op;
    logic [15:0] ra, rb;
    rst_n = 1'b0; or8 = 1'b1; or16 = 1'b1;
    park();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid8", 64'(ov8), 64'(0));
    check_eq("rst_data8", 64'(d8), 64'(0));
    check_eq("rst_err8", 64'(e8), 64'(0));
    check_eq("rst_valid16", 64'(ov16), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_ready8", 64'(r8), 64'(1));
    check_eq("rst_ready16", 64'(r16), 64'(1));

    // add then sub, back-to-back
    send8(3'b000, 8'h7F, 8'h01, 2);
    send8(3'b001, 8'h80, 8'h01, 2);
    // mul, abs, avg, and back-to-back
    send8(3'b010, 8'hFF, 8'hFF, 2);
    send8(3'b101, 8'h80, 8'h33, 2);
    send8(3'b110, 8'hFD, 8'h00, 2);
    send8(3'b011, 8'h80, 8'hFF, 2);
    park();
    drain();

    // modulo with an add queued behind it
    send8(3'b111, 8'd200, 8'd7, 10);
    send8(3'b000, 8'd1, 8'd1, 10);
    park();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("ready_busy8", 64'(r8), 64'(0));
    drain();

    // modulo by zero, then an ordinary op
    send8(3'b111, 8'h5A, 8'h00, 10);
    send8(3'b100, 8'h3C, 8'h0F, 10);
    park();
    drain();

    // backpressure: 3 ops with out_ready low for 5 cycles
    or8 = 1'b0;
    send8(3'b000, 8'h11, 8'h22, -1);
    send8(3'b010, 8'h0F, 8'h10, -1);
    send8(3'b001, 8'h05, 8'h09, -1);
    park();
    @(negedge clk);
    check_eq("ready_full8", 64'(r8), 64'(0));
    check_eq("valid_full8", 64'(ov8), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    or8 = 1'b1;
    drain();

    // reset during a divide: the op disappears
    send8(3'b111, 8'hC8, 8'h0B, 10);
    park();
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q8.delete();
    #1;
    check_eq("rstmid_valid8", 64'(ov8), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_eq("rstmid_noresult8", 64'(ov8), 64'(0));
    check_eq("rstmid_data8", 64'(d8), 64'(0));
    check_eq("rstmid_ready8", 64'(r8), 64'(1));

    // DATA_W = 16 regression
    send16(3'b101, 16'h8000, 16'h1234, 2);
    send16(3'b111, 16'd1000, 16'd3, 18);
    park();
    drain();

    // random traffic with random backpressure
    rnd_en = 1;
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom);
      ra = 16'($urandom);
      rb = (op == 3'b111 && $urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      send8(op, ra[7:0], rb[7:0], -1);
      park();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      ra = 16'($urandom);
      rb = (op == 3'b111 && $urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      send16(op, ra, rb, -1);
      park();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_en = 0;
    #1;
    or8 = 1'b1;
    or16 = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
